pll_loop_filter: RTL and testbench
==================================

// Module: pll_loop_filter
// PURPOSE
//  Proportional-integral loop filter closing the digital PLL loop. It consumes the 2-bit phase-error
//  code from the phase detector and produces the NCO phase step (i_step/i_ld side of the PLL). It
//  decimates error over fixed windows, updates a PI controller and flags loop lock.
// PARAMETERS
//  PHASE_BITS   32     NCO accumulator width; o_step is PHASE_BITS-1 bits
//  NOMINAL_STEP 2**20  free-running step loaded at reset; must be in [1, 2**(PHASE_BITS-1)-1]
//  UPDATE_DIV   16     enabled cycles per error window (>=2)
//  KP_SH        8      proportional gain = 2**KP_SH applied to the window sum
//  KI_SH        2      integral gain = 2**KI_SH applied to the window sum
//  LOCK_TOL     1      |window sum| <= LOCK_TOL counts as an in-tolerance window
//  LOCK_COUNT   64     consecutive in-tolerance windows needed to declare lock
// PORTS
//  i_clk     in   1             clock
//  i_rst_n   in   1             synchronous reset, active low
//  i_en      in   1             sample i_err this cycle
//  i_err     in   2             00 in phase, 01 lag (+1), 11 lead (-1), 10 invalid (treated as 0)
//  o_step    out  PHASE_BITS-1  NCO phase step, unsigned
//  o_ld      out  1             one-cycle strobe: o_step holds a new value
//  o_locked  out  1             loop locked
//  o_sat     out  1             last update was clamped
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge): o_step=NOMINAL_STEP, o_ld=0, o_locked=0, o_sat=0, integrator=0,
//   window count/sum=0, lock FSM=UNLOCKED. On the first edge after release, o_ld=1 for one cycle (initial load).
//  Window: with i_en=1, e(i_err) is added to a signed sum (clog2(UPDATE_DIV)+2 bits). The edge where count
//   reaches UPDATE_DIV-1 closes the window (S = sum incl. that sample), then count/sum restart at 0.
//   With i_en=0, count, sum, integrator and FSM hold.
//  Pipeline: edge N closes window; edge N+1 registers I' = clampI(I + (S<<<KI_SH)) and P = S<<<KP_SH;
//   edge N+2 registers o_step = clamp(NOMINAL_STEP + I' + P), o_ld=1, o_sat. o_ld is 0 otherwise.
//   Window closes may occur back to back (UPDATE_DIV>=2, so the pipeline never overlaps).
//  Arithmetic: integrator is signed PHASE_BITS+1 bits; step sum uses PHASE_BITS+2 bits signed.
//   clamp range [1, 2**(PHASE_BITS-1)-1]; o_sat=1 if the clamp acted, else 0; held until the next o_ld.
//   Anti-windup: clampI bounds I so NOMINAL_STEP+I stays within the clamp range.
//  Lock FSM (updated at edge N+1 of each window):
//   UNLOCKED: in-tol -> CANDIDATE (run=1); else stay.
//   CANDIDATE: in-tol -> run+1, reaching LOCK_COUNT -> LOCKED; out-of-tol -> UNLOCKED, run=0.
//   LOCKED: one out-of-tol window -> SUSPECT; SUSPECT: in-tol -> LOCKED, out-of-tol -> UNLOCKED.
//   o_locked=1 in LOCKED and SUSPECT.
//  Reset mid-window or mid-pipeline discards all pending work; only the post-reset initial load follows.
// CONFIGURATION
//  PLL_LF_GEAR_SHIFT_EN defined: while o_locked=1, the effective shifts are KP_SH-2 and KI_SH-2
//   (floored at 0) for updates whose stage N+1 sees o_locked=1. Not defined: gains are always KP_SH/KI_SH.
// STRUCTURE
//  pll_pkg: err_code_t enum {ERR_NONE=2'b00, ERR_LAG=2'b01, ERR_LEAD=2'b11}, lock_state_t enum
//   {UNLOCKED, CANDIDATE, LOCKED, SUSPECT}, function err_to_int(err_code_t) returning signed [1:0].
//  Sub-module pll_lock_detect: lock FSM and run counter; input window strobe and |S|; output o_locked.
// TESTING (PHASE_BITS=16, NOMINAL_STEP=1000, UPDATE_DIV=4, KP_SH=4, KI_SH=1, LOCK_TOL=1, LOCK_COUNT=4)
//  1 Release reset -> o_ld=1 for exactly one cycle, o_step=1000, o_locked=0, o_sat=0.
//  2 i_en=1, i_err=01 for 4 cycles -> S=+4, I=8; o_ld pulses 2 edges after the 4th sample, o_step=1072.
//  3 Fresh reset, i_err=11 x4 -> o_step=928. Then i_err=10 x4 -> S=0, o_step=992 (I held at -8).
//  4 i_err=00 for 4 windows -> o_locked=1 after the 4th; one 01x4 window -> still 1; second -> 0.
//  5 NOMINAL_STEP=32760, i_err=01 x4 -> o_step=32767, o_sat=1, I clamped at 7; next 00 window -> 32767, o_sat=0.
//  6 Drop i_en for 3 cycles mid-window -> no o_ld, window completes after 4 enabled samples.
//    Assert reset mid-pipeline -> no stale o_ld; output matches test 1.
//  7 With PLL_LF_GEAR_SHIFT_EN and locked, a 01x4 window -> step delta = +4*4 + I step of 4.

Source files
------------

// File: rtl/pll_loop_filter_pkg.sv
// Shared types and helpers for the PLL loop filter slice.
package pll_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LAG  = 2'b01,
    ERR_LEAD = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    UNLOCKED,
    CANDIDATE,
    LOCKED,
    SUSPECT
  } lock_state_t;

  // Phase-detector code to signed contribution (+1 lag, -1 lead, 0 otherwise).
  function automatic logic signed [1:0] err_to_int(err_code_t e);
    case (e)
      ERR_LAG:  return 2'sb01;
      ERR_LEAD: return 2'sb11;
      default:  return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/pll_loop_filter_if.sv
// Phase-error in / NCO step out bundle between the phase detector, loop filter and NCO.
interface pll_loop_filter_if #(
  parameter int unsigned PHASE_BITS = 32
);
  logic                  i_en;
  logic [1:0]            i_err;
  logic [PHASE_BITS-2:0] o_step;
  logic                  o_ld;
  logic                  o_locked;
  logic                  o_sat;

  modport master (
    output i_en, i_err,
    input  o_step, o_ld, o_locked, o_sat
  );

  modport slave (
    input  i_en, i_err,
    output o_step, o_ld, o_locked, o_sat
  );
endinterface

// File: rtl/pll_loop_filter_lock_detect.sv
// Lock detector: counts consecutive in-tolerance error windows and tracks lock with
// a one-window grace state before dropping lock.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int unsigned SW         = 4,
  parameter int unsigned LOCK_TOL   = 1,
  parameter int unsigned LOCK_COUNT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          win_i,
  input  logic [SW-1:0] s_abs_i,
  output logic          locked_o
);

  localparam int unsigned RW = $clog2(LOCK_COUNT + 1);

  lock_state_t   state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          in_tol;

  // State and run counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic, evaluated only on a window strobe.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    in_tol   = (32'(s_abs_i) <= LOCK_TOL);
    locked_o = (state_q == LOCKED) || (state_q == SUSPECT);
    if (win_i) begin
      case (state_q)
        UNLOCKED: begin
          if (in_tol) begin
            run_d   = RW'(1);
            state_d = (LOCK_COUNT <= 1) ? LOCKED : CANDIDATE;
          end
        end
        CANDIDATE: begin
          if (in_tol) begin
            run_d = run_q + RW'(1);
            if (run_d >= RW'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            run_d   = '0;
            state_d = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!in_tol) state_d = SUSPECT;
        end
        SUSPECT: begin
          if (in_tol) begin
            state_d = LOCKED;
          end else begin
            run_d   = '0;
            state_d = UNLOCKED;
          end
        end
        default: begin
          run_d   = '0;
          state_d = UNLOCKED;
        end
      endcase
    end
  end

endmodule

// File: rtl/pll_loop_filter.sv
// PI loop filter for the digital PLL: decimates the phase-error code over fixed windows,
// updates a clamped integrator plus proportional term and produces the NCO phase step.
// Optional build macro PLL_LF_GEAR_SHIFT_EN lowers both gains by 4x while locked.
module pll_loop_filter
  import pll_pkg::*;
#(
  parameter int unsigned PHASE_BITS   = 32,
  parameter int unsigned NOMINAL_STEP = 2**20,
  parameter int unsigned UPDATE_DIV   = 16,
  parameter int unsigned KP_SH        = 8,
  parameter int unsigned KI_SH        = 2,
  parameter int unsigned LOCK_TOL     = 1,
  parameter int unsigned LOCK_COUNT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pll_loop_filter_if.slave  bus
);

  localparam int unsigned CW = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
  localparam int unsigned SW = $clog2(UPDATE_DIV) + 2;
  localparam int unsigned IW = PHASE_BITS + 1;
  localparam int unsigned WW = PHASE_BITS + 2;

  localparam logic signed [WW-1:0] ONE_W  = WW'(1);
  localparam logic signed [WW-1:0] NOM_W  = WW'(NOMINAL_STEP);
  localparam logic signed [WW-1:0] MAX_W  = (ONE_W <<< (PHASE_BITS - 1)) - ONE_W;
  localparam logic signed [WW-1:0] IMIN_W = ONE_W - NOM_W;
  localparam logic signed [WW-1:0] IMAX_W = MAX_W - NOM_W;

  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [SW-1:0]     sum_q, sum_d;
  logic                     win_q, win_d;
  logic signed [SW-1:0]     s_q, s_d;
  logic                     pend_q, pend_d;
  logic signed [IW-1:0]     integ_q, integ_d;
  logic signed [WW-1:0]     p_q, p_d;
  logic [PHASE_BITS-2:0]    step_q, step_d;
  logic                     ld_q, ld_d;
  logic                     sat_q, sat_d;
  logic                     init_q, init_d;

  err_code_t                code;
  logic signed [SW-1:0]     sum_new;
  logic signed [WW-1:0]     s_w, isum, ssum;
  logic [SW-1:0]            s_abs;
  logic                     locked;
  int unsigned              kp_eff, ki_eff;

  pll_lock_detect #(
    .SW         (SW),
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .win_i    (win_q),
    .s_abs_i  (s_abs),
    .locked_o (locked)
  );

  // Pipeline and window registers; reset drops any in-flight update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      sum_q   <= '0;
      win_q   <= 1'b0;
      s_q     <= '0;
      pend_q  <= 1'b0;
      integ_q <= '0;
      p_q     <= '0;
      step_q  <= (PHASE_BITS-1)'(NOMINAL_STEP);
      ld_q    <= 1'b0;
      sat_q   <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      win_q   <= win_d;
      s_q     <= s_d;
      pend_q  <= pend_d;
      integ_q <= integ_d;
      p_q     <= p_d;
      step_q  <= step_d;
      ld_q    <= ld_d;
      sat_q   <= sat_d;
      init_q  <= init_d;
    end
  end

  // Window accumulation, PI update (window close + 1) and step output (window close + 2).
  always_comb begin
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    win_d   = 1'b0;
    s_d     = s_q;
    pend_d  = win_q;
    integ_d = integ_q;
    p_d     = p_q;
    step_d  = step_q;
    sat_d   = sat_q;
    ld_d    = init_q | pend_q;
    init_d  = 1'b0;

    // The invalid code 2'b10 is folded to ERR_NONE before the enum cast.
    code    = (bus.i_err == 2'b10) ? ERR_NONE : err_code_t'(bus.i_err);
    sum_new = sum_q + SW'(err_to_int(code));

    if (bus.i_en) begin
      if (cnt_q == CW'(UPDATE_DIV - 1)) begin
        cnt_d = '0;
        sum_d = '0;
        win_d = 1'b1;
        s_d   = sum_new;
      end else begin
        cnt_d = cnt_q + CW'(1);
        sum_d = sum_new;
      end
    end

`ifdef PLL_LF_GEAR_SHIFT_EN
    kp_eff = locked ? ((KP_SH >= 2) ? KP_SH - 2 : 0) : KP_SH;
    ki_eff = locked ? ((KI_SH >= 2) ? KI_SH - 2 : 0) : KI_SH;
`else
    kp_eff = KP_SH;
    ki_eff = KI_SH;
`endif

    s_w  = WW'(s_q);
    isum = WW'(integ_q) + (s_w <<< ki_eff);
    if (win_q) begin
      if (isum < IMIN_W)      integ_d = IMIN_W[IW-1:0];
      else if (isum > IMAX_W) integ_d = IMAX_W[IW-1:0];
      else                    integ_d = isum[IW-1:0];
      p_d = s_w <<< kp_eff;
    end

    ssum = NOM_W + WW'(integ_q) + p_q;
    if (pend_q) begin
      if (ssum < ONE_W) begin
        step_d = (PHASE_BITS-1)'(1);
        sat_d  = 1'b1;
      end else if (ssum > MAX_W) begin
        step_d = MAX_W[PHASE_BITS-2:0];
        sat_d  = 1'b1;
      end else begin
        step_d = ssum[PHASE_BITS-2:0];
        sat_d  = 1'b0;
      end
    end

    s_abs = s_q[SW-1] ? SW'(-s_q) : SW'(s_q);
  end

  assign bus.o_step   = step_q;
  assign bus.o_ld     = ld_q;
  assign bus.o_sat    = sat_q;
  assign bus.o_locked = locked;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Scoreboard bench for pll_loop_filter: two instances (nominal 1000 and 32760),
// directed windows push hand-computed step/sat/lock expectations; monitors pop on o_ld.
module tb_pll_loop_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  pll_loop_filter_if #(.PHASE_BITS(16)) ifa ();
  pll_loop_filter_if #(.PHASE_BITS(16)) ifb ();

  pll_loop_filter #(
    .PHASE_BITS(16), .NOMINAL_STEP(1000), .UPDATE_DIV(4),
    .KP_SH(4), .KI_SH(1), .LOCK_TOL(1), .LOCK_COUNT(4)
  ) dut_a (.i_clk(clk), .i_rst_n(rst_a_n), .bus(ifa.slave));

  pll_loop_filter #(
    .PHASE_BITS(16), .NOMINAL_STEP(32760), .UPDATE_DIV(4),
    .KP_SH(4), .KI_SH(1), .LOCK_TOL(1), .LOCK_COUNT(4)
  ) dut_b (.i_clk(clk), .i_rst_n(rst_b_n), .bus(ifb.slave));

`ifdef PLL_LF_GEAR_SHIFT_EN
  localparam int SUSP_STEP = 1020;  // P=4<<2, I=4<<0
  localparam int DROP_STEP = 1024;  // I=8, P=16
`else
  localparam int SUSP_STEP = 1072;  // P=4<<4, I=4<<1
  localparam int DROP_STEP = 1080;  // I=16, P=64
`endif

  typedef struct {
    int    step;
    bit    sat;
    bit    locked;
    string tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare(exp_t e, int step, logic sat, logic lk);
    chk({e.tag, ".step"}, step, e.step);
    chk({e.tag, ".sat"}, int'(sat), int'(e.sat));
    chk({e.tag, ".locked"}, int'(lk), int'(e.locked));
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    if (ifa.o_ld !== 1'b0) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL a.unexpected_ld: got o_ld=%b step=%0d, expected no load", ifa.o_ld, ifa.o_step);
      end else begin
        compare(qa.pop_front(), int'(ifa.o_step), ifa.o_sat, ifa.o_locked);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (ifb.o_ld !== 1'b0) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL b.unexpected_ld: got o_ld=%b step=%0d, expected no load", ifb.o_ld, ifb.o_step);
      end else begin
        compare(qb.pop_front(), int'(ifb.o_step), ifb.o_sat, ifb.o_locked);
      end
    end
  end

  task automatic push(bit b, int step, bit sat, bit lk, string tag);
    exp_t e;
    e.step = step; e.sat = sat; e.locked = lk; e.tag = tag;
    if (!b) qa.push_back(e);
    else    qb.push_back(e);
  endtask

  task automatic drive(bit b, bit en, logic [1:0] err);
    if (!b) begin ifa.i_en = en; ifa.i_err = err; end
    else    begin ifb.i_en = en; ifb.i_err = err; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit b);
    if (!b) ifa.i_en = 1'b0;
    else    ifb.i_en = 1'b0;
  endtask

  task automatic win(bit b, logic [1:0] err, int step, bit sat, bit lk, string tag);
    push(b, step, sat, lk, tag);
    repeat (4) drive(b, 1'b1, err);
    idle(b);
  endtask

  task automatic do_reset(bit b, int nom, string tag);
    if (!b) begin rst_a_n = 1'b0; ifa.i_en = 1'b0; end
    else    begin rst_b_n = 1'b0; ifb.i_en = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    if (!b) begin
      chk({tag, ".rst_step"}, int'(ifa.o_step), nom);
      chk({tag, ".rst_ld"}, int'(ifa.o_ld), 0);
      chk({tag, ".rst_locked"}, int'(ifa.o_locked), 0);
      chk({tag, ".rst_sat"}, int'(ifa.o_sat), 0);
    end else begin
      chk({tag, ".rst_step"}, int'(ifb.o_step), nom);
      chk({tag, ".rst_ld"}, int'(ifb.o_ld), 0);
      chk({tag, ".rst_locked"}, int'(ifb.o_locked), 0);
      chk({tag, ".rst_sat"}, int'(ifb.o_sat), 0);
    end
    push(b, nom, 1'b0, 1'b0, {tag, ".init"});
    if (!b) rst_a_n = 1'b1;
    else    rst_b_n = 1'b1;
  endtask

  task automatic drain(bit b, string tag);
    int left;
    left = 1;
    for (int i = 0; i < 30; i++) begin
      left = (!b) ? qa.size() : qb.size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    if (left != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s.timeout: got %0d loads outstanding, expected 0", tag, left);
      if (!b) qa.delete();
      else    qb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.i_en = 1'b0; ifa.i_err = 2'b00;
    ifb.i_en = 1'b0; ifb.i_err = 2'b00;

    // Reset, initial load, single lag window.
    do_reset(0, 1000, "t1");
    win(0, 2'b01, 1072, 1'b0, 1'b0, "t2.lag");
    drain(0, "t2");

    // Lead window then an invalid-code window (integrator holds at -8).
    do_reset(0, 1000, "t3");
    win(0, 2'b11, 928, 1'b0, 1'b0, "t3.lead");
    win(0, 2'b10, 992, 1'b0, 1'b0, "t3.inval");
    drain(0, "t3");

    // Lock acquisition, suspect grace window, then loss of lock.
    do_reset(0, 1000, "t4");
    win(0, 2'b00, 1000, 1'b0, 1'b0, "t4.w1");
    win(0, 2'b00, 1000, 1'b0, 1'b0, "t4.w2");
    win(0, 2'b00, 1000, 1'b0, 1'b0, "t4.w3");
    win(0, 2'b00, 1000, 1'b0, 1'b1, "t4.w4");
    win(0, 2'b01, SUSP_STEP, 1'b0, 1'b1, "t4.suspect");
    win(0, 2'b01, DROP_STEP, 1'b0, 1'b0, "t4.drop");
    drain(0, "t4");

    // Enable gaps inside a window.
    do_reset(0, 1000, "t6");
    push(0, 1072, 1'b0, 1'b0, "t6.gap");
    repeat (2) drive(0, 1'b1, 2'b01);
    repeat (3) drive(0, 1'b0, 2'b01);
    repeat (2) drive(0, 1'b1, 2'b01);
    idle(0);
    drain(0, "t6.gap");

    // Reset right after a window closes: its update must never appear.
    repeat (4) drive(0, 1'b1, 2'b01);
    idle(0);
    do_reset(0, 1000, "t6.mid");
    drain(0, "t6.mid");
    win(0, 2'b00, 1000, 1'b0, 1'b0, "t6.after");
    drain(0, "t6.after");

    // Upper clamp with integrator anti-windup.
    do_reset(1, 32760, "t5");
    win(1, 2'b01, 32767, 1'b1, 1'b0, "t5.clamp");
    win(1, 2'b00, 32767, 1'b0, 1'b0, "t5.hold");
    drain(1, "t5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
